// File: rtl/dct_transpose_buffer_pkg.sv
// Shared constants and types for the DCT row/column transpose buffer.
package dct_transpose_buffer_pkg;

    localparam int DCT_N          = 8;
    localparam int DCT_DATA_WIDTH = 10;

    typedef struct packed {
        logic [DCT_DATA_WIDTH-1:0] data;
        logic                      last;
    } tpose_sample_t;

    typedef enum logic {
        TP_BYPASS    = 1'b0,
        TP_TRANSPOSE = 1'b1
    } tpose_mode_e;

endpackage

// File: rtl/dct_transpose_buffer_if.sv
// Stream bundle between the row-pass producer, the transpose buffer and the column-pass consumer.
interface dct_transpose_buffer_if
    import dct_transpose_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_WIDTH,
    parameter int N          = DCT_N
);
    localparam int CNT_W = $clog2(N);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_transpose;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [2*CNT_W-1:0]    out_idx;

    modport master (
        output in_data, in_valid, in_transpose, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_idx
    );

    modport slave (
        input  in_data, in_valid, in_transpose, out_ready,
        output in_ready, out_data, out_valid, out_last, out_idx
    );

endinterface

// File: rtl/dct_transpose_buffer_idx_counter.sv
// Outer/inner block index counter; inner steps per accepted sample, outer steps on inner wrap.
module tpose_idx_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] outer,
    output logic [CNT_W-1:0] inner,
    output logic             done
);
    localparam logic [CNT_W-1:0] MAX_IDX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] outer_r;
    logic [CNT_W-1:0] inner_r;
    logic             wrap_s;
    logic             done_s;

    // Decode inner wrap and end-of-block for the sample being accepted now.
    always_comb begin
        wrap_s = 1'b0;
        done_s = 1'b0;
        if (advance && (inner_r == MAX_IDX)) begin
            wrap_s = 1'b1;
            done_s = (outer_r == MAX_IDX);
        end else begin
            wrap_s = 1'b0;
            done_s = 1'b0;
        end
    end

    // Index registers; N is a power of two so both roll back to zero at block end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outer_r <= {CNT_W{1'b0}};
            inner_r <= {CNT_W{1'b0}};
        end else if (advance) begin
            inner_r <= inner_r + CNT_W'(1'b1);
            if (wrap_s) begin
                outer_r <= outer_r + CNT_W'(1'b1);
            end
        end
    end

    assign outer = outer_r;
    assign inner = inner_r;
    assign done  = done_s;

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong N x N transpose memory: row-major in, column-major (or row-major) out.
module dct_transpose_buffer
    import dct_transpose_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_WIDTH,
    parameter int N          = DCT_N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dct_transpose_buffer_if.slave bus
);
    localparam int               CNT_W   = $clog2(N);
    localparam int               ADDR_W  = 2 * CNT_W + 1;
    localparam int               DEPTH   = 2 * N * N;
    localparam logic [CNT_W-1:0] MAX_IDX = {CNT_W{1'b1}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [1:0]            full_r;
    logic [1:0]            full_nxt_s;
    tpose_mode_e           mode_r [2];
    logic                  wr_bank_r;
    logic                  rd_bank_r;

    logic                  in_ready_s;
    logic                  rd_valid_s;
    logic                  wr_fire_s;
    logic                  rd_fire_s;
    logic                  wr_first_s;
    logic                  wr_done_s;
    logic                  rd_done_s;
    logic [CNT_W-1:0]      wr_row_s;
    logic [CNT_W-1:0]      wr_col_s;
    logic [CNT_W-1:0]      rd_outer_s;
    logic [CNT_W-1:0]      rd_inner_s;
    logic [ADDR_W-1:0]     wr_addr_s;
    logic [ADDR_W-1:0]     rd_addr_s;

    // Writer owns only a non-full bank, reader only a full one, so they never collide.
    assign in_ready_s = ~full_r[wr_bank_r];
    assign rd_valid_s = full_r[rd_bank_r];
    assign wr_fire_s  = bus.in_valid & in_ready_s;
    assign rd_fire_s  = rd_valid_s & bus.out_ready;
    assign wr_first_s = wr_fire_s && (wr_row_s == {CNT_W{1'b0}}) && (wr_col_s == {CNT_W{1'b0}});
    assign wr_addr_s  = {wr_bank_r, wr_row_s, wr_col_s};

    tpose_idx_counter #(.CNT_W(CNT_W)) u_wr_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (wr_fire_s),
        .outer   (wr_row_s),
        .inner   (wr_col_s),
        .done    (wr_done_s)
    );

    tpose_idx_counter #(.CNT_W(CNT_W)) u_rd_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (rd_fire_s),
        .outer   (rd_outer_s),
        .inner   (rd_inner_s),
        .done    (rd_done_s)
    );

    // Full flags: writer completion sets its bank, reader completion clears its bank.
    always_comb begin
        full_nxt_s = full_r;
        for (int b = 0; b < 2; b++) begin
            if (wr_done_s && (wr_bank_r == 1'(b))) begin
                full_nxt_s[b] = 1'b1;
            end else if (rd_done_s && (rd_bank_r == 1'(b))) begin
                full_nxt_s[b] = 1'b0;
            end else begin
                full_nxt_s[b] = full_r[b];
            end
        end
    end

    // Bank ownership and occupancy; a reset drops any partial block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
        end else begin
            full_r <= full_nxt_s;
            if (wr_done_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            if (rd_done_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
        end
    end

    // Block mode is captured once, on the block's first accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r[0] <= TP_BYPASS;
            mode_r[1] <= TP_BYPASS;
        end else if (wr_first_s) begin
            mode_r[wr_bank_r] <= tpose_mode_e'(bus.in_transpose);
        end
    end

    // Sample storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_addr_s] <= bus.in_data;
        end
    end

    // Read address: transposed blocks swap the row and column roles of the read indices.
    always_comb begin
        rd_addr_s = {rd_bank_r, rd_outer_s, rd_inner_s};
        if (mode_r[rd_bank_r] == TP_TRANSPOSE) begin
            rd_addr_s = {rd_bank_r, rd_inner_s, rd_outer_s};
        end else begin
            rd_addr_s = {rd_bank_r, rd_outer_s, rd_inner_s};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = rd_valid_s;
    assign bus.out_data  = mem_r[rd_addr_s];
    assign bus.out_last  = rd_valid_s && (rd_outer_s == MAX_IDX) && (rd_inner_s == MAX_IDX);
    assign bus.out_idx   = {rd_outer_s, rd_inner_s};

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed and randomised bench for the ping-pong transpose buffer (N=8, 10-bit samples).
module tb_dct_transpose_buffer;

    localparam int NN = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [9:0]  wr_src   [NN];
    logic [9:0]  got_data [NN];
    logic        got_last [NN];
    logic [5:0]  got_idx  [NN];
    logic [16:0] exp_q    [$];

    dct_transpose_buffer_if #(.DATA_WIDTH(10), .N(8)) bus ();

    dct_transpose_buffer #(.DATA_WIDTH(10), .N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Position in the written block that the i-th output sample comes from.
    function automatic int src_pos(input logic tp, input int i);
        return tp ? ((i % 8) * 8 + i / 8) : i;
    endfunction

    task automatic fill_src(input int base);
        for (int i = 0; i < NN; i++) wr_src[i] = 10'(base + i);
    endtask

    task automatic drive_block(input int n, input logic tp, input int flip_at, input int vpct,
                               output int sent, output int cyc);
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 1500) begin
            @(posedge clk); #1;
            bus.in_valid     = (int'($urandom_range(99)) < vpct);
            bus.in_data      = wr_src[sent];
            bus.in_transpose = (sent >= flip_at) ? ~tp : tp;
            @(negedge clk);
            cyc++;
            if (bus.in_valid && bus.in_ready) sent++;
        end
    endtask

    task automatic collect_block(input int start, input int n, input int rpct,
                                 output int got, output int cyc);
        got = 0;
        cyc = 0;
        while (got < n && cyc < 2000) begin
            @(posedge clk); #1;
            bus.out_ready = (int'($urandom_range(99)) < rpct);
            @(negedge clk);
            cyc++;
            if (bus.out_valid && bus.out_ready) begin
                got_data[start + got] = bus.out_data;
                got_last[start + got] = bus.out_last;
                got_idx[start + got]  = bus.out_idx;
                got++;
            end
        end
    endtask

    task automatic idle_in();
        @(posedge clk); #1 bus.in_valid = 1'b0;
    endtask

    task automatic idle_out();
        @(posedge clk); #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 10'd0; bus.in_transpose = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_idx} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b idx=%0d expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.out_idx);
        end
    endtask

    task automatic test_transpose();
        int sent, cyc, got, rcyc, wait_cyc;
        logic [16:0] exp;
        fill_src(0);
        wait_cyc = 0;
        fork
            begin drive_block(NN, 1'b1, NN, 100, sent, cyc); idle_in(); end
            begin
                while (wait_cyc < 200) begin
                    @(posedge clk); #1 bus.out_ready = 1'b0;
                    @(negedge clk);
                    if (bus.out_valid) break;
                    wait_cyc++;
                end
                collect_block(0, NN, 100, got, rcyc);
                idle_out();
            end
        join
        checks++;
        if (cyc !== 64 || sent !== 64) begin
            errors++; $display("FAIL tp_write_cycles: got %0d/%0d expected 64/64", sent, cyc);
        end
        checks++;
        if (wait_cyc !== 64) begin
            errors++; $display("FAIL tp_valid_latency: got %0d expected 64", wait_cyc);
        end
        for (int i = 0; i < NN; i++) begin
            exp = {10'(src_pos(1'b1, i)), (i == NN - 1), 6'(i)};
            checks++;
            if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                errors++; $display("FAIL tp_s%0d: got %h expected %h", i, {got_data[i], got_last[i], got_idx[i]}, exp);
            end
        end
    endtask

    task automatic test_bypass();
        int s1, s2, s3, c, got, rcyc;
        logic [16:0] exp;
        int   base_t [3] = '{0, 100, 200};
        logic tp_t   [3] = '{1'b0, 1'b0, 1'b1};
        fork
            begin
                fill_src(0);   drive_block(NN, 1'b0, NN, 100, s1, c);
                fill_src(100); drive_block(NN, 1'b0, 30, 100, s2, c);
                fill_src(200); drive_block(NN, 1'b1, 30, 100, s3, c);
                idle_in();
            end
            begin
                for (int b = 0; b < 3; b++) begin
                    collect_block(0, NN, 100, got, rcyc);
                    for (int i = 0; i < NN; i++) begin
                        exp = {10'(base_t[b] + src_pos(tp_t[b], i)), (i == NN - 1), 6'(i)};
                        checks++;
                        if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                            errors++; $display("FAIL mode_b%0d_s%0d: got %h expected %h", b, i, {got_data[i], got_last[i], got_idx[i]}, exp);
                        end
                    end
                end
                idle_out();
            end
        join
        checks++;
        if (s1 + s2 + s3 !== 192) begin
            errors++; $display("FAIL mode_sent: got %0d expected 192", s1 + s2 + s3);
        end
    endtask

    task automatic test_backpressure();
        int s, c1, c2, c3, got, rcyc;
        logic [16:0] exp;
        bus.out_ready = 1'b0;
        fill_src(0);   drive_block(NN, 1'b0, NN, 100, s, c1);
        fill_src(200); drive_block(NN, 1'b1, NN, 100, s, c2);
        idle_in();
        @(negedge clk);
        checks++;
        if ({c1, c2} !== {32'd64, 32'd64} || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_both_full: got c=%0d,%0d rdy=%b vld=%b expected 64,64 0 1", c1, c2, bus.in_ready, bus.out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_data, bus.out_last, bus.out_idx} !== {10'd0, 1'b0, 6'd0}) begin
                errors++; $display("FAIL bp_hold0_c%0d: got %h expected 0", k, {bus.out_data, bus.out_last, bus.out_idx});
            end
        end
        fork
            begin fill_src(400); drive_block(NN, 1'b0, NN, 100, s, c3); idle_in(); end
            begin
                collect_block(0, 10, 100, got, rcyc);
                idle_out();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({bus.in_ready, bus.out_data, bus.out_last, bus.out_idx} !== {1'b0, 10'd10, 1'b0, 6'd10}) begin
                        errors++; $display("FAIL bp_hold10_c%0d: got %h expected %h", k,
                                           {bus.in_ready, bus.out_data, bus.out_last, bus.out_idx}, {1'b0, 10'd10, 1'b0, 6'd10});
                    end
                end
                collect_block(10, 54, 100, got, rcyc);
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_ready_early: got %b expected 0", bus.in_ready);
                end
                idle_out();
                @(negedge clk);
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_ready_return: got %b expected 1", bus.in_ready);
                end
                for (int i = 0; i < NN; i++) begin
                    exp = {10'(i), (i == NN - 1), 6'(i)};
                    checks++;
                    if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                        errors++; $display("FAIL bp_b0_s%0d: got %h expected %h", i, {got_data[i], got_last[i], got_idx[i]}, exp);
                    end
                end
                for (int b = 1; b < 3; b++) begin
                    collect_block(0, NN, 100, got, rcyc);
                    for (int i = 0; i < NN; i++) begin
                        exp = {10'(200 * b + src_pos(b == 1, i)), (i == NN - 1), 6'(i)};
                        checks++;
                        if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                            errors++; $display("FAIL bp_b%0d_s%0d: got %h expected %h", b, i, {got_data[i], got_last[i], got_idx[i]}, exp);
                        end
                    end
                end
                idle_out();
            end
        join
        checks++;
        if (s !== 64) begin
            errors++; $display("FAIL bp_block3_sent: got %0d expected 64", s);
        end
    endtask

    task automatic test_simultaneous();
        int s, got;
        int wc [3];
        int rc [3];
        logic [16:0] exp;
        int   base_t [3] = '{0, 300, 600};
        logic tp_t   [3] = '{1'b0, 1'b1, 1'b0};
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    fill_src(base_t[b]);
                    drive_block(NN, tp_t[b], NN, 100, s, wc[b]);
                end
                idle_in();
            end
            begin
                for (int b = 0; b < 3; b++) begin
                    collect_block(0, NN, 100, got, rc[b]);
                    for (int i = 0; i < NN; i++) begin
                        exp = {10'(base_t[b] + src_pos(tp_t[b], i)), (i == NN - 1), 6'(i)};
                        checks++;
                        if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                            errors++; $display("FAIL sim_b%0d_s%0d: got %h expected %h", b, i, {got_data[i], got_last[i], got_idx[i]}, exp);
                        end
                    end
                end
                idle_out();
            end
        join
        checks++;
        if ({wc[0], wc[1], wc[2]} !== {32'd64, 32'd64, 32'd64}) begin
            errors++; $display("FAIL sim_write_cycles: got %0d %0d %0d expected 64 64 64", wc[0], wc[1], wc[2]);
        end
        checks++;
        if ({rc[0], rc[1], rc[2]} !== {32'd128, 32'd64, 32'd64}) begin
            errors++; $display("FAIL sim_read_cycles: got %0d %0d %0d expected 128 64 64", rc[0], rc[1], rc[2]);
        end
    endtask

    task automatic test_random();
        int s, c, got, rcyc;
        logic tp;
        logic [16:0] exp;
        exp_q.delete();
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    tp = 1'($urandom_range(1));
                    for (int i = 0; i < NN; i++) wr_src[i] = 10'($urandom_range(1023));
                    for (int i = 0; i < NN; i++) exp_q.push_back({wr_src[src_pos(tp, i)], (i == NN - 1), 6'(i)});
                    drive_block(NN, tp, int'($urandom_range(63, 1)), 50, s, c);
                end
                idle_in();
            end
            begin
                for (int b = 0; b < 20; b++) begin
                    collect_block(0, NN, 50, got, rcyc);
                    checks++;
                    if (got !== 64) begin
                        errors++; $display("FAIL rnd_b%0d_count: got %0d expected 64", b, got);
                    end
                    for (int i = 0; i < NN; i++) begin
                        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
                        if (i < got) begin
                            checks++;
                            if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                                errors++; $display("FAIL rnd_b%0d_s%0d: got %h expected %h", b, i, {got_data[i], got_last[i], got_idx[i]}, exp);
                            end
                        end
                    end
                end
                idle_out();
            end
        join
    endtask

    task automatic test_reset_mid();
        int s, c, got, rcyc;
        logic [16:0] exp;
        bus.out_ready = 1'b0;
        fill_src(700);
        drive_block(NN, 1'b0, NN, 100, s, c);
        fork
            begin fill_src(800); drive_block(37, 1'b1, NN, 100, s, c); end
            begin collect_block(0, 12, 100, got, rcyc); idle_out(); end
        join
        @(posedge clk); #1;
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_idx} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            errors++; $display("FAIL rstmid_outputs: got rdy=%b vld=%b last=%b idx=%0d expected 1 0 0 0",
                               bus.in_ready, bus.out_valid, bus.out_last, bus.out_idx);
        end
        fill_src(0);
        fork
            begin drive_block(NN, 1'b0, NN, 100, s, c); idle_in(); end
            begin collect_block(0, NN, 100, got, rcyc); idle_out(); end
        join
        for (int i = 0; i < NN; i++) begin
            exp = {10'(i), (i == NN - 1), 6'(i)};
            checks++;
            if ({got_data[i], got_last[i], got_idx[i]} !== exp) begin
                errors++; $display("FAIL rstmid_s%0d: got %h expected %h", i, {got_data[i], got_last[i], got_idx[i]}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_bypass();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
- Ping-pong N×N transpose memory between the row-pass and column-pass DCT PE arrays.
- Accepts one block of N×N samples in row-major order and emits it column-major (transpose mode) or row-major (bypass mode).
- Two banks, so one block can be written while the previous block is read.
- Parametrised successor of the fixed 8-deep, 10-bit ram_if storage: generic width, depth and mode, with valid/ready flow control on both sides.

Parameters:
- DATA_WIDTH, 10, sample width in bits.
- N, 8, block dimension; block holds N*N samples; N ≥ 2, power of two.
- CNT_W, $clog2(N), row/column index width (derived, not overridable).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_data, input, DATA_WIDTH, sample (row-major order).
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, buffer can accept; transfer when in_valid && in_ready.
- in_transpose, input, 1, mode for the block being written; sampled on the block's first accepted sample.
- out_data, output, DATA_WIDTH, sample.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, consumer accepts; transfer when out_valid && out_ready.
- out_last, output, 1, high with the final (N*N-th) sample of a block.
- out_idx, output, 2*CNT_W, {outer, inner} read index of the current sample.

Behaviour:
- Interface: one clock, clk; synchronous, active-low reset rst_n.
- Storage: two banks of N*N × DATA_WIDTH flops.
  - Per-bank state: full flag and mode bit.
- Write side:
  - State: wrBank (1 b), wrRow, wrCol (CNT_W each).
  - in_ready = !full[wrBank].
  - On accept: store at [wrBank][wrRow][wrCol]; wrCol++. When wrCol wraps, wrRow++.
  - First sample of a block (wrRow=0, wrCol=0) latches in_transpose into mode[wrBank].
  - Last sample (wrRow=wrCol=N-1): set full[wrBank], toggle wrBank, reset both indices.
- Read side:
  - State: rdBank, rdOuter, rdInner.
  - out_valid = full[rdBank].
  - Address = mode ? [rdInner][rdOuter] : [rdOuter][rdInner].
  - out_data, out_last and out_idx are combinational from current state. Zero latency: out_valid rises the cycle after the last write into that bank.
  - On accept: rdInner++; when rdInner wraps, rdOuter++.
  - Last sample: clear full[rdBank], toggle rdBank, reset both indices.
- While out_valid && !out_ready: out_data, out_last and out_idx stay stable.
- Boundaries:
  - Both banks full: in_ready=0. It returns to 1 the cycle after the reader finishes a bank.
  - Both empty: out_valid=0.
  - Same cycle, writer completes bank A and reader completes bank B: set full[A] and clear full[B] together. No lost or duplicated block.
  - Writer and reader never address the same bank simultaneously. The writer only owns non-full banks; the reader only owns the full bank.
  - in_transpose changes mid-block: ignored until the next block's first sample.
  - in_valid low mid-block: indices hold; no timeout.
- Reset values (rst_n low at clk edge, including mid-block):
  - full=0, wrBank=rdBank=0, all indices 0, mode=0.
  - Outputs: in_ready=1 from the cycle after reset, out_valid=0, out_last=0, out_idx=0. out_data don't-care (reads bank 0).
  - Partial blocks are discarded. Sample storage is not reset.
- Throughput: one sample per cycle each side sustained. Block latency N*N cycles.

Decomposition:
- Shared package entries:
  - typedef tpose_sample_t {logic [DATA_WIDTH-1:0] data; logic last;}, width fixed at 10 for the DCT datapath.
  - Constant DCT_N = 8.
  - Enum tpose_mode_e {TP_BYPASS=0, TP_TRANSPOSE=1}.
- One natural sub-module: tpose_idx_counter (CNT_W outer/inner counter with advance, wrap and done).
  - Instantiated twice: write side and read side.

Test Plan (N=8, DATA_WIDTH=10):
- Single block, transpose=1: write values 0..63 back-to-back, out_ready=1.
  - out_valid rises the cycle after sample 63.
  - Output sequence 0,8,16,…,56,1,9,…,63; out_last only on 63.
- Bypass: same stimulus with transpose=0 → output 0..63 in order. Then toggle in_transpose at sample 30 of the next block → no effect.
- Backpressure / ping-pong: stream 3 blocks with out_ready=0.
  - in_ready drops after block 2 (sample 127); block 3 stalls.
  - Raise out_ready: block 1 drains fully, then in_ready returns 1 on the following cycle.
  - out_data holds while stalled.
- Simultaneous completion: align writer finishing block 2 with reader's out_last of block 1.
  - Next cycle: rdBank=1, full={1,0}→{0,1} correctly, no bubble beyond spec.
- Random valid/ready (50% each), 20 blocks of random data, random mode → scoreboard matches a transposed/bypassed reference model exactly.
- Reset at write sample 37 and read sample 12 → after reset out_valid=0, in_ready=1. A fresh block 0..63 emerges correct with no stale data.
